// File: rtl/task3.sv
// ARC4 decryption top for DE1-SoC: decrypts the length-prefixed message in ct
// into pt once after reset, using the 24-bit key {14'b0, SW}.

module task3_ram (
  input  logic       clock,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);
  logic [7:0] mem_data [0:255];

  // Read-during-write returns the old contents.
  always_ff @(posedge clock) begin
    if (wren) mem_data[address] <= data;
    q <= mem_data[address];
  end
endmodule

module task3_altsyncram (
  input  logic       clock,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);
  // Mirrors the vendor IP hierarchy so contents are reachable at
  // altsyncram_component.m_default.altsyncram_inst.mem_data.
  generate
    if (1) begin : m_default
      task3_ram altsyncram_inst (
        .clock   (clock),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
      );
    end
  endgenerate
endmodule

module task3_ct_ram (
  input  logic       clock,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);
  task3_altsyncram altsyncram_component (
    .clock   (clock),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );
endmodule

module task3 (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);
  typedef enum logic [3:0] {
    INIT, KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J,
    PRGA_LEN, PRGA_WR_LEN, PRGA_RD_I, PRGA_RD_J, PRGA_WR_I, PRGA_WR_J,
    PRGA_RD_PAD, PRGA_WR_PT, DONE
  } state_t;

  logic        rst_n;
  logic [23:0] key;
  logic [7:0]  key_byte;
  state_t      state, state_n;
  logic [7:0]  i, i_n, j, j_n, si, si_n, sj, sj_n, len, len_n;
  logic [1:0]  km, km_n;
  logic [7:0]  s_addr, s_data, s_q, ct_addr, ct_q, pt_addr, pt_data, pt_q;
  logic        s_wren, pt_wren;
  logic        unused_inputs;

  assign rst_n         = KEY[3];
  assign key           = {14'b0, SW};
  assign unused_inputs = &{1'b0, KEY[2:0], pt_q};
  // km tracks i mod 3 through KSA so no divider is needed.
  assign key_byte = (km == 2'd0) ? key[23:16] : (km == 2'd1) ? key[15:8] : key[7:0];

  task3_ram s (
    .clock (CLOCK_50), .address (s_addr), .data (s_data), .wren (s_wren), .q (s_q)
  );
  task3_ct_ram ct (
    .clock (CLOCK_50), .address (ct_addr), .data (8'h00), .wren (1'b0), .q (ct_q)
  );
  task3_ram pt (
    .clock (CLOCK_50), .address (pt_addr), .data (pt_data), .wren (pt_wren), .q (pt_q)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      len   <= 8'd0;
      km    <= 2'd0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      si    <= si_n;
      sj    <= sj_n;
      len   <= len_n;
      km    <= km_n;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    si_n    = si;
    sj_n    = sj;
    len_n   = len;
    km_n    = km;
    s_addr  = i;
    s_data  = 8'h00;
    s_wren  = 1'b0;
    ct_addr = 8'h00;
    pt_addr = i;
    pt_data = 8'h00;
    pt_wren = 1'b0;
    case (state)
      INIT: begin
        s_data = i;
        s_wren = 1'b1;
        i_n    = i + 8'd1;
        if (i == 8'hFF) state_n = KSA_RD_I;
      end
      KSA_RD_I: state_n = KSA_RD_J;
      KSA_RD_J: begin
        si_n    = s_q;
        j_n     = j + s_q + key_byte;
        s_addr  = j_n;
        state_n = KSA_WR_I;
      end
      KSA_WR_I: begin
        s_data  = s_q;
        s_wren  = 1'b1;
        state_n = KSA_WR_J;
      end
      KSA_WR_J: begin
        s_addr = j;
        s_data = si;
        s_wren = 1'b1;
        i_n    = i + 8'd1;
        km_n   = (km == 2'd2) ? 2'd0 : km + 2'd1;
        if (i == 8'hFF) begin
          j_n     = 8'd0;
          state_n = PRGA_LEN;
        end else begin
          state_n = KSA_RD_I;
        end
      end
      PRGA_LEN: state_n = PRGA_WR_LEN;
      PRGA_WR_LEN: begin
        pt_addr = 8'd0;
        pt_data = ct_q;
        pt_wren = 1'b1;
        len_n   = ct_q;
        state_n = (ct_q == 8'd0) ? DONE : PRGA_RD_I;
      end
      PRGA_RD_I: begin
        i_n     = i + 8'd1;
        s_addr  = i_n;
        state_n = PRGA_RD_J;
      end
      PRGA_RD_J: begin
        ct_addr = i;
        si_n    = s_q;
        j_n     = j + s_q;
        s_addr  = j_n;
        state_n = PRGA_WR_I;
      end
      PRGA_WR_I: begin
        ct_addr = i;
        s_data  = s_q;
        s_wren  = 1'b1;
        sj_n    = s_q;
        state_n = PRGA_WR_J;
      end
      PRGA_WR_J: begin
        ct_addr = i;
        s_addr  = j;
        s_data  = si;
        s_wren  = 1'b1;
        state_n = PRGA_RD_PAD;
      end
      PRGA_RD_PAD: begin
        ct_addr = i;
        s_addr  = si + sj;
        state_n = PRGA_WR_PT;
      end
      PRGA_WR_PT: begin
        ct_addr = i;
        pt_data = s_q ^ ct_q;
        pt_wren = 1'b1;
        state_n = (i == len) ? DONE : PRGA_RD_I;
      end
      DONE: state_n = DONE;
      default: state_n = INIT;
    endcase
  end

  assign LEDR = {9'b0, state == DONE};
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
endmodule

// File: tb/tb_task3.sv
// Bench for task3: runs directed ARC4 decryptions and compares pt and s
// against a behavioral RC4 model.
`timescale 1ns/1ps

module tb_task3;
  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] ct_img    [0:255];
  logic [7:0] model_out [0:255];
  logic [7:0] model_s   [0:255];
  logic [7:0] prev_pt   [0:255];
  logic [7:0] exp_q [$];

  task3 dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  // Behavioral RC4: model_out[1..len] = keystream ^ ct_img, model_s = final S.
  task automatic model_rc4(input logic [23:0] key, input int len);
    logic [7:0] sb [0:255];
    logic [7:0] kb [0:2];
    logic [7:0] ii, jj, t, idx;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) sb[k] = k[7:0];
    jj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      jj     = jj + sb[k] + kb[k % 3];
      t      = sb[k];
      sb[k]  = sb[jj];
      sb[jj] = t;
    end
    ii = 8'd0;
    jj = 8'd0;
    model_out[0] = len[7:0];
    for (int k = 1; k <= len; k++) begin
      ii     = ii + 8'd1;
      jj     = jj + sb[ii];
      t      = sb[ii];
      sb[ii] = sb[jj];
      sb[jj] = t;
      idx    = sb[ii] + sb[jj];
      model_out[k] = sb[idx] ^ ct_img[k];
    end
    for (int k = 0; k < 256; k++) model_s[k] = sb[k];
  endtask

  // driver tasks
  task automatic load_ct();
    for (int k = 0; k < 256; k++)
      dut.ct.altsyncram_component.m_default.altsyncram_inst.mem_data[k] = ct_img[k];
  endtask

  task automatic start_run(input logic [9:0] sw);
    KEY = 4'b0111;
    SW  = sw;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    @(posedge CLOCK_50);
    #1;
    load_ct();
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 4000;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge CLOCK_50);
      #1;
      if (LEDR[0]) begin
        ok  = 1'b1;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    KEY = 4'b0111;
    SW  = 10'($urandom_range(0, 1023));
    for (int n = 0; n < 4; n++) begin
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (LEDR !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_ledr: got %h expected %h", LEDR, 10'h000);
      end
      n_cmp++;
      if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}}) begin
        n_fail++;
        $display("FAIL reset_hex: got %h expected %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
      end
      n_cmp++;
      if (dut.pt_wren !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pt_write: got %b expected 0", dut.pt_wren);
      end
    end
  endtask

  task automatic test_key_zero();
    bit ok;
    int cyc;
    logic [7:0] exp;
    ct_img[0] = 8'd5;
    ct_img[1] = 8'h3C;
    ct_img[2] = 8'hA5;
    ct_img[3] = 8'h00;
    ct_img[4] = 8'hFF;
    ct_img[5] = 8'h5A;
    model_rc4(24'h000000, 5);
    start_run(10'h000);
    wait_done(ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL key0_done: no done within %0d cycles", cyc);
    end
    n_cmp++;
    if (dut.pt.mem_data[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL key0_len: got %0d expected 5", dut.pt.mem_data[0]);
    end
    for (int k = 1; k <= 5; k++) exp_q.push_back(model_out[k]);
    for (int k = 1; k <= 5; k++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dut.pt.mem_data[k] !== exp) begin
        n_fail++;
        $display("FAIL key0_pt[%0d]: got %h expected %h", k, dut.pt.mem_data[k], exp);
      end
    end
    repeat (20) @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (LEDR !== 10'h001) begin
      n_fail++;
      $display("FAIL key0_done_hold: got %h expected %h", LEDR, 10'h001);
    end
  endtask

  task automatic test_full_length();
    bit ok;
    int cyc;
    logic [7:0] exp;
    ct_img[0] = 8'd255;
    for (int k = 1; k < 256; k++) ct_img[k] = 8'($urandom_range(0, 255));
    model_rc4(24'h0003FF, 255);
    start_run(10'h3FF);
    wait_done(ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_done: no done within %0d cycles", cyc);
    end
    n_cmp++;
    if (dut.pt.mem_data[0] !== 8'd255) begin
      n_fail++;
      $display("FAIL full_len: got %0d expected 255", dut.pt.mem_data[0]);
    end
    for (int k = 1; k < 256; k++) exp_q.push_back(model_out[k]);
    for (int k = 1; k < 256; k++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dut.pt.mem_data[k] !== exp) begin
        n_fail++;
        $display("FAIL full_pt[%0d]: got %h expected %h", k, dut.pt.mem_data[k], exp);
      end
    end
    for (int k = 0; k < 256; k++) begin
      n_cmp++;
      if (dut.s.mem_data[k] !== model_s[k]) begin
        n_fail++;
        $display("FAIL full_s[%0d]: got %h expected %h", k, dut.s.mem_data[k], model_s[k]);
      end
    end
    for (int k = 0; k < 256; k++) prev_pt[k] = model_out[k];
  endtask

  task automatic test_len_zero();
    bit ok;
    int cyc;
    ct_img[0] = 8'd0;
    start_run(10'h155);
    wait_done(ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL len0_done: no done within %0d cycles", cyc);
    end
    n_cmp++;
    if (dut.pt.mem_data[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL len0_len: got %0d expected 0", dut.pt.mem_data[0]);
    end
    for (int k = 1; k < 256; k++) begin
      n_cmp++;
      if (dut.pt.mem_data[k] !== prev_pt[k]) begin
        n_fail++;
        $display("FAIL len0_untouched[%0d]: got %h expected %h", k, dut.pt.mem_data[k], prev_pt[k]);
      end
    end
    @(negedge CLOCK_50);
    KEY[3] = 1'b0;
    #1;
    n_cmp++;
    if (LEDR !== 10'h000) begin
      n_fail++;
      $display("FAIL len0_done_drop: got %h expected %h", LEDR, 10'h000);
    end
  endtask

  task automatic test_round_trip();
    bit ok;
    int cyc;
    int len;
    string msg;
    logic [7:0] exp;
    msg = "Attack at dawn: ARC4 on DE1-SoC!";
    len = msg.len();
    ct_img[0] = 8'(len);
    for (int k = 1; k <= len; k++) ct_img[k] = msg[k-1];
    model_rc4(24'h000118, len);
    for (int k = 1; k <= len; k++) ct_img[k] = model_out[k];
    start_run(10'h118);
    wait_done(ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL trip_done: no done within %0d cycles", cyc);
    end
    for (int k = 1; k <= len; k++) exp_q.push_back(msg[k-1]);
    for (int k = 1; k <= len; k++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dut.pt.mem_data[k] !== exp) begin
        n_fail++;
        $display("FAIL trip_pt[%0d]: got %h expected %h", k, dut.pt.mem_data[k], exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int cyc;
    logic [7:0] exp;
    ct_img[0] = 8'd40;
    for (int k = 1; k <= 40; k++) ct_img[k] = 8'($urandom_range(0, 255));
    model_rc4(24'h0002A7, 40);
    start_run(10'h2A7);
    // Roughly a dozen bytes into PRGA.
    repeat (1350) @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (LEDR[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_early_done: got %b expected 0", LEDR[0]);
    end
    @(negedge CLOCK_50);
    KEY[3] = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (LEDR !== 10'h000) begin
      n_fail++;
      $display("FAIL mid_reset_ledr: got %h expected %h", LEDR, 10'h000);
    end
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    wait_done(ok, cyc);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_done: no done within %0d cycles", cyc);
    end
    for (int k = 0; k <= 40; k++) exp_q.push_back(model_out[k]);
    for (int k = 0; k <= 40; k++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dut.pt.mem_data[k] !== exp) begin
        n_fail++;
        $display("FAIL mid_pt[%0d]: got %h expected %h", k, dut.pt.mem_data[k], exp);
      end
    end
  endtask

  initial begin
    KEY = 4'b0111;
    SW  = 10'h000;
    test_reset();
    test_key_zero();
    test_full_length();
    test_len_zero();
    test_round_trip();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
